// File: rtl/ds_dac_pdm.sv
// ds_dac_pdm: delta-sigma DAC front end.
// Signed PCM samples arrive over a valid/ready handshake into a one-entry hold
// register, are upsampled by R through a 2-stage CIC interpolator (N=2, M=1)
// and noise-shaped into a 1-bit PDM stream by a first-order modulator.
// Optional build macro: DS_DAC_2ND_ORDER_EN selects a second-order modulator
// (input must then be kept within +/-0.75 full scale by the caller).
//
// Handshake: a sample transfers on a clk edge where din_valid && din_ready.
// din_ready is high exactly while the hold register is empty; din_valid held
// while din_ready is low is ignored, so each presented sample is taken once.

module ds_dac_pdm #(
  parameter int WIDTH = 16,
  parameter int R     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             pdm_out,
  output logic             frame_out,
  output logic             underrun
);

  localparam int LOG2R = $clog2(R);
  // Integrator width: WIDTH + log2(R) + 1, wrap-around arithmetic.
  localparam int IW    = WIDTH + LOG2R + 1;
`ifdef DS_DAC_2ND_ORDER_EN
  localparam int AW    = WIDTH + 4;
`else
  localparam int AW    = WIDTH + 3;
`endif
  // Feedback magnitude: one full-scale step.
  localparam logic signed [AW-1:0] FS = AW'(1) <<< (WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Hold register and frame counter
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] hold_q;
  logic                    full_q;
  logic [LOG2R-1:0]        cnt_q;
  logic                    frame_cke;
  logic                    capture;

  assign capture   = din_valid && !full_q;
  assign frame_cke = cke && (cnt_q == LOG2R'(R - 1));
  assign din_ready = !full_q;
  assign frame_out = frame_cke && !rst;

  // Hold register: fill on handshake, drain on the frame boundary cke.
  // A capture needs full_q=0 and a drain needs full_q=1, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (capture) begin
      hold_q <= din;
      full_q <= 1'b1;
    end else if (frame_cke && full_q) begin
      full_q <= 1'b0;
    end
  end

  // Frame counter wraps R-1 -> 0 naturally since R is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cke) begin
      cnt_q <= cnt_q + LOG2R'(1);
    end
  end

  // Sticky underrun: frame boundary reached with nothing to consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (frame_cke && !full_q) begin
      underrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // CIC interpolator: frame-rate combs, zero-stuffing, cke-rate integrators
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] x_low_q;
  logic signed [WIDTH-1:0] x_new;
  logic signed [WIDTH:0]   c1;
  logic signed [WIDTH:0]   c1_q;
  logic signed [WIDTH+1:0] c2;
  logic signed [IW-1:0]    u;
  logic signed [IW-1:0]    i1_q;
  logic signed [IW-1:0]    i2_q;
  logic signed [IW-1:0]    i1_next;
  logic signed [IW-1:0]    i2_next;
  logic signed [WIDTH:0]   y;

  // On an empty frame the previous sample is repeated (comb sees x_new == x_low).
  assign x_new = full_q ? hold_q : x_low_q;

  // Comb stages evaluated on the value entering the CIC this frame.
  always_comb begin
    c1 = {x_new[WIDTH-1], x_new} - {x_low_q[WIDTH-1], x_low_q};
    c2 = {c1[WIDTH], c1} - {c1_q[WIDTH], c1_q};
  end

  // Zero-stuffed upsample feeding the integrator chain.
  always_comb begin
    u       = frame_cke ? {{(IW-WIDTH-2){c2[WIDTH+1]}}, c2} : '0;
    i1_next = i1_q + u;
    i2_next = i2_q + i1_next;
  end

  // Comb delay registers advance only at frame rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_low_q <= '0;
      c1_q    <= '0;
    end else if (frame_cke) begin
      x_low_q <= x_new;
      c1_q    <= c1;
    end
  end

  // Integrators advance every cke; overflow wraps and cancels in the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q <= '0;
      i2_q <= '0;
    end else if (cke) begin
      i1_q <= i1_next;
      i2_q <= i2_next;
    end
  end

  // Remove the CIC gain of R; result is WIDTH+1 bits signed.
  assign y = i2_q[IW-1:LOG2R];

  // ---------------------------------------------------------------------------
  // Noise-shaping modulator
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] fb;
  logic signed [AW-1:0] y_ext;
  logic signed [AW-1:0] acc1_q;
  logic signed [AW-1:0] acc1_next;
  logic                 decision;

  assign fb    = pdm_out ? FS : -FS;
  assign y_ext = {{(AW-WIDTH-1){y[WIDTH]}}, y};

`ifdef DS_DAC_2ND_ORDER_EN
  logic signed [AW-1:0] acc2_q;
  logic signed [AW-1:0] acc2_next;

  // Two cascaded error accumulators; quantiser looks at the second.
  always_comb begin
    acc1_next = acc1_q + y_ext - fb;
    acc2_next = acc2_q + acc1_next - fb;
    decision  = !acc2_next[AW-1];
  end

  // Second-stage accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc2_q <= '0;
    end else if (cke) begin
      acc2_q <= acc2_next;
    end
  end
`else
  // Single error accumulator; quantiser is its sign.
  always_comb begin
    acc1_next = acc1_q + y_ext - fb;
    decision  = !acc1_next[AW-1];
  end
`endif

  // First accumulator and output bit, updated once per cke.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1_q  <= '0;
      pdm_out <= 1'b0;
    end else if (cke) begin
      acc1_q  <= acc1_next;
      pdm_out <= decision;
    end
  end

endmodule

// File: tb/tb_ds_dac_pdm.sv
// tb_ds_dac_pdm: directed self-checking bench for ds_dac_pdm.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_ds_dac_pdm;

  localparam int WIDTH = 16;
  localparam int R     = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cke = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic             pdm_out;
  logic             frame_out;
  logic             underrun;

  always #5 clk = ~clk;

  ds_dac_pdm #(.WIDTH(WIDTH), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .cke       (cke),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .pdm_out   (pdm_out),
    .frame_out (frame_out),
    .underrun  (underrun)
  );

  // Handshake monitors: running counts, tests take deltas.
  int cap_cnt      = 0;
  int ready_hi_cnt = 0;
  always @(posedge clk) begin
    if (!rst && din_valid && din_ready) cap_cnt <= cap_cnt + 1;
    if (!rst && din_ready) ready_hi_cnt <= ready_hi_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  // Pass when |got - exp| <= tol.
  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  int max_run;
  int run_len;
  logic last_bit;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cke = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic stream(input int value);
    din = WIDTH'(value);
    din_valid = 1'b1;
  endtask

  // Issue n cke pulses spaced 'period' clocks apart; count ones and frames.
  task automatic run_cke(input int n, input int period,
                         output int ones, output int frames, output int first_frame);
    ones = 0; frames = 0; first_frame = 0;
    for (int k = 1; k <= n; k++) begin
      cke = 1'b1;
      #1;
      if (frame_out) begin
        frames++;
        if (first_frame == 0) first_frame = k;
      end
      @(negedge clk);
      cke = 1'b0;
      if (pdm_out) ones++;
      if (pdm_out == last_bit) run_len++;
      else run_len = 1;
      last_bit = pdm_out;
      if (run_len > max_run) max_run = run_len;
      for (int j = 1; j < period; j++) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int ones, frames, first, c0, r0;
    max_run = 0; run_len = 0; last_bit = 1'b0;

    // Reset state
    do_reset();
    check("rst_pdm",      int'(pdm_out),   0, 0);
    check("rst_ready",    int'(din_ready), 1, 0);
    check("rst_frame",    int'(frame_out), 0, 0);
    check("rst_underrun", int'(underrun),  0, 0);

    // Zero input -> 50% duty
    stream(0);
    run_cke(2*R, 4, ones, frames, first);
    run_cke(256, 4, ones, frames, first);
    check("zero_ones", ones, 128, 1);
    check("zero_underrun", int'(underrun), 0, 0);

    // Half scale positive / negative
    do_reset();
    stream(16384);
    run_cke(64, 4, ones, frames, first);
    run_cke(256, 4, ones, frames, first);
    check("pos_half_ones", ones, 192, 2);
    stream(-16384);
    run_cke(64, 4, ones, frames, first);
    run_cke(256, 4, ones, frames, first);
    check("neg_half_ones", ones, 64, 2);

    // Negative full scale -> all zeros
    stream(-32768);
    run_cke(64, 4, ones, frames, first);
    run_cke(256, 4, ones, frames, first);
    check("neg_fs_ones", ones, 0, 0);
    check("neg_fs_underrun", int'(underrun), 0, 0);

    // Positive full scale -> (almost) all ones
    stream(32767);
    run_cke(64, 4, ones, frames, first);
    run_cke(256, 4, ones, frames, first);
    check("pos_fs_ones", ones, 256, 1);

    // cke held high continuously
    stream(16384);
    run_cke(64, 1, ones, frames, first);
    run_cke(256, 1, ones, frames, first);
    check("cont_cke_ones", ones, 192, 2);
    check("cont_cke_underrun", int'(underrun), 0, 0);

    // Handshake: one capture while ready low, then underrun on empty frame
    do_reset();
    run_cke(2, 4, ones, frames, first);
    c0 = cap_cnt;
    stream(1000);
    @(negedge clk);
    check("hs_ready_low", int'(din_ready), 0, 0);
    r0 = ready_hi_cnt;
    run_cke(5, 4, ones, frames, first);
    check("hs_no_early_frame", frames, 0, 0);
    din_valid = 1'b0;
    check("hs_ready_held_low", ready_hi_cnt - r0, 0, 0);
    run_cke(1, 4, ones, frames, first);
    check("hs_frame", frames, 1, 0);
    check("hs_one_capture", cap_cnt - c0, 1, 0);
    check("hs_ready_after", int'(din_ready), 1, 0);
    run_cke(7, 4, ones, frames, first);
    check("hs_underrun_before", int'(underrun), 0, 0);
    run_cke(1, 4, ones, frames, first);
    check("hs_underrun_after", int'(underrun), 1, 0);
    run_cke(40, 4, ones, frames, first);
    run_cke(256, 4, ones, frames, first);
    check("hs_repeat_ones", ones, 132, 1);

    // Reset mid-frame with hold register full
    stream(555);
    @(negedge clk);
    din_valid = 1'b0;
    check("rf_full", int'(din_ready), 0, 0);
    run_cke(3, 4, ones, frames, first);
    rst = 1'b1;
    @(negedge clk);
    check("rf_pdm", int'(pdm_out), 0, 0);
    check("rf_ready", int'(din_ready), 1, 0);
    check("rf_underrun", int'(underrun), 0, 0);
    rst = 1'b0;
    run_cke(R, 4, ones, frames, first);
    check("rf_first_frame", first, R, 0);
    check("rf_frames", frames, 1, 0);
    check("rf_discarded", int'(underrun), 1, 0);

`ifdef DS_DAC_2ND_ORDER_EN
    // Second-order loop
    do_reset();
    stream(8192);
    run_cke(128, 4, ones, frames, first);
    run_cke(1024, 4, ones, frames, first);
    check("o2_ones", ones, 640, 4);
    stream(0);
    run_cke(128, 4, ones, frames, first);
    max_run = 0; run_len = 0;
    run_cke(512, 4, ones, frames, first);
    check("o2_max_run", max_run, 4, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
